dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the load/store path: serves the datamem_en/rw/size requests
//  issued by the control unit for LDR/STR (byte and word). Holds a word-organised RAM,
//  inserts a programmable number of wait states, and signals completion with a one-cycle
//  ready pulse. Sits between the EX/MEM datapath and the writeback mux.
// PARAMETERS
//  DEPTH_WORDS   64   RAM depth in 32-bit words; word index = addr[31:2] mod DEPTH_WORDS
//  WAIT_STATES   1    extra cycles spent in WAIT before the access commits (0..15)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  reset       in   1   synchronous, active-high; highest priority
//  datamem_en  in   1   request valid (level); sampled only in IDLE
//  rw          in   1   1 = read (LDR), 0 = write (STR)
//  size        in   1   1 = byte, 0 = word
//  addr        in   32  byte address
//  wdata       in   32  store data; byte store uses wdata[7:0]
//  rdata       out  32  load data; held until the next completed read
//  ready       out  1   one-cycle completion pulse
//  busy        out  1   high in WAIT and DONE
//  fault       out  1   misalignment fault pulse (DMEM_ALIGN_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, rdata=0, ready=0, busy=0, fault=0; RAM contents not cleared.
//  - States: IDLE -> WAIT -> DONE -> IDLE.
//  - IDLE: datamem_en=1 at edge t captures rw/size/addr/wdata, loads cnt=WAIT_STATES, -> WAIT.
//  - WAIT: cnt!=0 -> cnt-1; cnt==0 -> perform access on that edge, -> DONE.
//  - DONE: ready=1 for exactly one cycle, -> IDLE. ready first high in the cycle after edge
//    t+WAIT_STATES+1 (WAIT_STATES=0: two edges after capture).
//  - Inputs ignored in WAIT/DONE; changes there do not affect the captured request.
//  - Requester drops datamem_en in the ready cycle; if still high on return to IDLE it is a
//    new request (back-to-back allowed, one idle cycle between transactions).
//  - Word read: rdata = RAM[idx]. Byte read: rdata = {24'b0, lane addr[1:0]}, little-endian
//    (lane k = bits 8k+7:8k), zero-extended.
//  - Word write: RAM[idx] = wdata. Byte write: only lane addr[1:0] <= wdata[7:0].
//  - Without alignment check, word access ignores addr[1:0].
//  - Writes leave rdata unchanged.
//  - Address beyond depth wraps modulo DEPTH_WORDS; no error.
//  - Reset in WAIT aborts: no RAM write, no ready. Reset on the commit edge wins: no write.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: word access with addr[1:0]!=0 performs no RAM read/write;
//    DONE asserts ready and fault together for one cycle, rdata unchanged.
//    Byte accesses are never faulted.
//  Not defined: fault tied 0, word access is silently forced aligned.
// STRUCTURE
//  dmem_pkg: state enum (IDLE/WAIT/DONE), SIZE_BYTE=1/SIZE_WORD=0, RW_READ=1/RW_WRITE=0,
//    WAIT_CNT_W=4.
//  Sub-module dmem_byte_lane: combinational lane steering from addr[1:0]/size; produces
//    4-bit write mask, merged write word and zero-extended read byte.
//  Top holds FSM, capture registers, counter and RAM array.
// TESTING
//  1 word write 0xDEADBEEF @0x10, then word read @0x10 -> ready after WAIT_STATES+2 edges,
//    rdata=0xDEADBEEF.
//  2 byte write 0xAA @0x13 over word 0x11223344 @0x10 -> word read 0xAA223344; byte read
//    @0x12 -> 0x00000022.
//  3 WAIT_STATES=0 and 3: measure capture-to-ready latency = 2 and 5 edges; ready exactly
//    1 cycle wide, busy high throughout.
//  4 reset asserted mid-WAIT of write 0x55 @0x20 -> no ready, IDLE next cycle; read @0x20
//    returns prior value.
//  5 datamem_en held high across ready -> second transaction starts after one IDLE cycle;
//    addr/wdata changed in WAIT are ignored.
//  6 DMEM_ALIGN_CHECK_EN: word write @0x22 -> ready+fault pulse, RAM unchanged. Macro off:
//    same write lands at 0x20, fault=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// Holds the FSM state encoding, the size/rw encodings used by the control
// unit and the width of the wait-state counter.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   localparam logic SIZE_BYTE  = 1'b1;
   localparam logic SIZE_WORD  = 1'b0;
   localparam logic RW_READ    = 1'b1;
   localparam logic RW_WRITE   = 1'b0;

   localparam int   WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_byte_lane.sv
// dmem_byte_lane: purely combinational little-endian lane steering.
// Write side: turns a lane/size pair into a 4-bit byte write mask and a write
// word with the store byte replicated into its lane.
// Read side: picks the addressed byte out of a RAM word, zero-extended.
module dmem_byte_lane
   import dmem_pkg::*;
(
   input  logic [1:0]  wr_lane,
   input  logic        wr_size,
   input  logic [31:0] wdata,
   input  logic [1:0]  rd_lane,
   input  logic [31:0] rd_word,
   output logic [3:0]  wr_mask,
   output logic [31:0] wr_word,
   output logic [31:0] rd_byte_ext
);

   // Per-lane write enable and write data: word stores hit all four lanes,
   // byte stores only the addressed lane, always with wdata[7:0].
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_mask[gi] = (wr_size == SIZE_WORD) || (wr_lane == 2'(gi));
      assign wr_word[8*gi +: 8] = (wr_size == SIZE_BYTE) ? wdata[7:0]
                                                         : wdata[8*gi +: 8];
   end

   // Lane k lives in bits 8k+7:8k; upper bits are zero.
   always_comb begin
      rd_byte_ext = {24'b0, rd_word[8*rd_lane +: 8]};
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind the LDR/STR request
// interface. A request seen in IDLE is captured, held for WAIT_STATES extra
// cycles, committed on the last WAIT edge and acknowledged with a one-cycle
// ready pulse from DONE.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault misaligned word
// accesses (no RAM access, fault pulses with ready). Without it, word
// accesses silently ignore addr[1:0] and fault stays 0.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        datamem_en,
   input  logic        rw,
   input  logic        size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        fault
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   // Control state
   dmem_state_e           state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  fault_q, fault_d;

   // Captured request
   logic                  rw_q, rw_d;
   logic                  size_q, size_d;
   logic [1:0]            lane_q, lane_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [31:0]           wdata_q, wdata_d;

   // Last completed read: raw RAM word plus how to present it
   logic [31:0]           rd_word_q;
   logic [1:0]            rd_lane_q, rd_lane_d;
   logic                  rd_size_q, rd_size_d;

   logic [31:0]           ram [DEPTH_WORDS];

   logic                  commit;
   logic                  misaligned;
   logic                  ram_we;
   logic                  ram_re;
   logic [29:0]           word_addr;
   logic [3:0]            wr_mask;
   logic [31:0]           wr_word;
   logic [31:0]           rd_byte_ext;

   assign word_addr = addr[31:2];

   // The access happens on the edge that leaves WAIT with the counter spent.
   assign commit = (state_q == WAIT) && (cnt_q == '0);

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = (size_q == SIZE_WORD) && (lane_q != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Reset on the commit edge must suppress the write.
   assign ram_we = commit && !reset && (rw_q == RW_WRITE) && !misaligned;
   assign ram_re = commit && (rw_q == RW_READ) && !misaligned;

   dmem_byte_lane u_lane (
      .wr_lane     (lane_q),
      .wr_size     (size_q),
      .wdata       (wdata_q),
      .rd_lane     (rd_lane_q),
      .rd_word     (rd_word_q),
      .wr_mask     (wr_mask),
      .wr_word     (wr_word),
      .rd_byte_ext (rd_byte_ext)
   );

   // Next-state, capture and output computation for the IDLE/WAIT/DONE FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_d   = 1'b0;
      busy_d    = busy_q;
      fault_d   = 1'b0;
      rw_d      = rw_q;
      size_d    = size_q;
      lane_d    = lane_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      rd_lane_d = rd_lane_q;
      rd_size_d = rd_size_q;
      unique case (state_q)
         IDLE: begin
            if (datamem_en) begin
               rw_d    = rw;
               size_d  = size;
               lane_d  = addr[1:0];
               idx_d   = IDX_W'({2'b00, word_addr} % DEPTH_WORDS);
               wdata_d = wdata;
               cnt_d   = WAIT_CNT_W'(WAIT_STATES);
               busy_d  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - WAIT_CNT_W'(1);
            end else begin
               ready_d = 1'b1;
               fault_d = misaligned;
               state_d = DONE;
               if (ram_re) begin
                  rd_lane_d = lane_q;
                  rd_size_d = size_q;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Control registers; reset returns to an idle, quiet interface.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         fault_q   <= 1'b0;
         rd_lane_q <= 2'b00;
         rd_size_q <= SIZE_WORD;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         fault_q   <= fault_d;
         rd_lane_q <= rd_lane_d;
         rd_size_q <= rd_size_d;
      end
   end

   // Request capture registers; only meaningful once a request is taken.
   always_ff @(posedge clk) begin
      rw_q    <= rw_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
   end

   // RAM write port with byte enables; contents are never cleared.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
               ram[idx_q][8*b +: 8] <= wr_word[8*b +: 8];
            end
         end
      end
   end

   // Registered RAM read; the word is held until the next completed read.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_word_q <= '0;
      end else if (ram_re) begin
         rd_word_q <= ram[idx_q];
      end
   end

   assign rdata = (rd_size_q == SIZE_BYTE) ? rd_byte_ext : rd_word_q;
   assign ready = ready_q;
   assign busy  = busy_q;
   assign fault = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of the data-memory responder.
// Main instance uses WAIT_STATES=1; two extra instances (0 and 3 wait states)
// share the same inputs and are used for latency measurements.
// Honours DMEM_ALIGN_CHECK_EN for the misaligned word-store case.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        datamem_en;
   logic        rw;
   logic        size;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [31:0] rdata1, rdata0, rdata3;
   logic        ready1, ready0, ready3;
   logic        busy1, busy0, busy3;
   logic        fault1, fault0, fault3;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_rdata;
   logic        last_fault;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) dut (
      .clk(clk), .reset(reset), .datamem_en(datamem_en), .rw(rw), .size(size),
      .addr(addr), .wdata(wdata), .rdata(rdata1), .ready(ready1), .busy(busy1),
      .fault(fault1)
   );

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut_w0 (
      .clk(clk), .reset(reset), .datamem_en(datamem_en), .rw(rw), .size(size),
      .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0),
      .fault(fault0)
   );

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut_w3 (
      .clk(clk), .reset(reset), .datamem_en(datamem_en), .rw(rw), .size(size),
      .addr(addr), .wdata(wdata), .rdata(rdata3), .ready(ready3), .busy(busy3),
      .fault(fault3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: got=%h", tag, got);
      end
   endtask

   // One request on the main instance; inputs are scrambled during WAIT.
   task automatic txn(input string tag, input logic r, input logic s,
                      input logic [31:0] a, input logic [31:0] d, input int exp_lat);
      int lat;
      @(negedge clk);
      datamem_en = 1'b1; rw = r; size = s; addr = a; wdata = d;
      @(posedge clk);
      @(negedge clk);
      datamem_en = 1'b0; rw = ~r; addr = ~a; wdata = ~d;
      lat = 1;
      while (ready1 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      last_rdata = rdata1;
      last_fault = fault1;
      check({tag, ".latency"}, lat, exp_lat);
      @(negedge clk);
      check({tag, ".pulse_end"}, {31'b0, ready1}, 32'd0);
   endtask

   int   lat0, lat3, w0, w3;
   logic b0ok, b3ok, seen;

   initial begin
      reset = 1'b1; datamem_en = 1'b0; rw = RW_READ; size = SIZE_WORD;
      addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset.rdata", rdata1, 32'h0);
      check("reset.ready", {31'b0, ready1}, 32'd0);
      check("reset.busy",  {31'b0, busy1}, 32'd0);
      check("reset.fault", {31'b0, fault1}, 32'd0);

      // 1: word write then word read
      txn("t1.wr", RW_WRITE, SIZE_WORD, 32'h10, 32'hDEADBEEF, 3);
      check("t1.wr.rdata_held", last_rdata, 32'h0);
      txn("t1.rd", RW_READ, SIZE_WORD, 32'h10, 32'h0, 3);
      check("t1.rd.rdata", last_rdata, 32'hDEADBEEF);

      // 2: byte merge and byte read
      txn("t2.wr", RW_WRITE, SIZE_WORD, 32'h10, 32'h11223344, 3);
      txn("t2.wb", RW_WRITE, SIZE_BYTE, 32'h13, 32'h123456AA, 3);
      txn("t2.rd", RW_READ, SIZE_WORD, 32'h10, 32'h0, 3);
      check("t2.rd.rdata", last_rdata, 32'hAA223344);
      txn("t2.rb2", RW_READ, SIZE_BYTE, 32'h12, 32'h0, 3);
      check("t2.rb2.rdata", last_rdata, 32'h00000022);
      txn("t2.rb3", RW_READ, SIZE_BYTE, 32'h13, 32'h0, 3);
      check("t2.rb3.rdata", last_rdata, 32'h000000AA);
      txn("t2.wx", RW_WRITE, SIZE_WORD, 32'h40, 32'h0, 3);
      check("t2.wx.rdata_held", last_rdata, 32'h000000AA);
      txn("t2.wrap", RW_READ, SIZE_WORD, 32'h110, 32'h0, 3);
      check("t2.wrap.rdata", last_rdata, 32'hAA223344);

      // 3: latency on the 0- and 3-wait-state instances
      repeat (8) @(negedge clk);
      @(negedge clk);
      datamem_en = 1'b1; rw = RW_READ; size = SIZE_WORD; addr = 32'h10;
      @(posedge clk);
      lat0 = 0; lat3 = 0; w0 = 0; w3 = 0; b0ok = 1'b1; b3ok = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) datamem_en = 1'b0;
         if (ready0 === 1'b1) begin w0++; if (lat0 == 0) lat0 = k; end
         if (ready3 === 1'b1) begin w3++; if (lat3 == 0) lat3 = k; end
         if ((lat0 == 0 || lat0 == k) && busy0 !== 1'b1) b0ok = 1'b0;
         if ((lat3 == 0 || lat3 == k) && busy3 !== 1'b1) b3ok = 1'b0;
      end
      check("t3.w0.latency", lat0, 2);
      check("t3.w3.latency", lat3, 5);
      check("t3.w0.width", w0, 1);
      check("t3.w3.width", w3, 1);
      check("t3.w0.busy", {31'b0, b0ok}, 32'd1);
      check("t3.w3.busy", {31'b0, b3ok}, 32'd1);
      check("t3.w0.rdata", rdata0, 32'hAA223344);

      // 4: reset mid-WAIT and on the commit edge
      txn("t4.pre", RW_WRITE, SIZE_WORD, 32'h20, 32'h12345678, 3);
      @(negedge clk);
      datamem_en = 1'b1; rw = RW_WRITE; size = SIZE_WORD; addr = 32'h20; wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      datamem_en = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t4.mid.busy", {31'b0, busy1}, 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (ready1 !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      check("t4.mid.no_ready", {31'b0, seen}, 32'd0);
      txn("t4.rd1", RW_READ, SIZE_WORD, 32'h20, 32'h0, 3);
      check("t4.rd1.rdata", last_rdata, 32'h12345678);
      @(negedge clk);
      datamem_en = 1'b1; rw = RW_WRITE; size = SIZE_WORD; addr = 32'h20; wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      datamem_en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t4.commit.ready", {31'b0, ready1}, 32'd0);
      check("t4.commit.busy", {31'b0, busy1}, 32'd0);
      txn("t4.rd2", RW_READ, SIZE_WORD, 32'h20, 32'h0, 3);
      check("t4.rd2.rdata", last_rdata, 32'h12345678);

      // 5: back-to-back with datamem_en held, inputs changed during WAIT
      @(negedge clk);
      datamem_en = 1'b1; rw = RW_WRITE; size = SIZE_WORD; addr = 32'h30; wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      addr = 32'h34; wdata = 32'h11111111;
      @(negedge clk);
      @(negedge clk);
      check("t5.first.ready", {31'b0, ready1}, 32'd1);
      @(negedge clk);
      check("t5.gap.busy", {31'b0, busy1}, 32'd0);
      @(negedge clk);
      datamem_en = 1'b0;
      check("t5.second.busy", {31'b0, busy1}, 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ready1 === 1'b1) seen = 1'b1;
      end
      check("t5.second.ready", {31'b0, seen}, 32'd1);
      txn("t5.rd30", RW_READ, SIZE_WORD, 32'h30, 32'h0, 3);
      check("t5.rd30.rdata", last_rdata, 32'hCAFEF00D);
      txn("t5.rd34", RW_READ, SIZE_WORD, 32'h34, 32'h0, 3);
      check("t5.rd34.rdata", last_rdata, 32'h11111111);

      // 6: misaligned word store
      txn("t6.wr", RW_WRITE, SIZE_WORD, 32'h22, 32'h77665544, 3);
`ifdef DMEM_ALIGN_CHECK_EN
      check("t6.wr.fault", {31'b0, last_fault}, 32'd1);
      check("t6.wr.rdata_held", last_rdata, 32'h11111111);
      txn("t6.rd", RW_READ, SIZE_WORD, 32'h20, 32'h0, 3);
      check("t6.rd.rdata", last_rdata, 32'h12345678);
`else
      check("t6.wr.fault", {31'b0, last_fault}, 32'd0);
      txn("t6.rd", RW_READ, SIZE_WORD, 32'h20, 32'h0, 3);
      check("t6.rd.rdata", last_rdata, 32'h77665544);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
